// File: rtl/alsu_param.sv
// alsu_param: two-stage ALU/shifter with operand bypass, reduction modes and invalid-op LED toggle.
// Define ALSU_PARAM_ERR_CNT_EN to add the saturating invalid-operation counter on err_cnt.
module alsu_param #(
    parameter int unsigned WIDTH          = 3,
    parameter string       INPUT_PRIORITY = "A",
    parameter string       FULL_ADDER     = "ON",
    parameter int unsigned LED_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [2:0]                opcode,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic                      cin,
    input  logic                      serial_in,
    input  logic                      direction,
    input  logic                      red_op_A,
    input  logic                      red_op_B,
    input  logic                      bypass_A,
    input  logic                      bypass_B,
    output logic signed [2*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic [LED_W-1:0]          leds
`ifdef ALSU_PARAM_ERR_CNT_EN
    ,
    output logic [7:0]                err_cnt
`endif
);

    localparam int unsigned OW     = 2 * WIDTH;
    localparam bit          PrioA  = (INPUT_PRIORITY != "B");
    localparam bit          UseCin = (FULL_ADDER == "ON");

    typedef enum logic [2:0] {
        OpOr     = 3'd0,
        OpXor    = 3'd1,
        OpAdd    = 3'd2,
        OpMult   = 3'd3,
        OpShift  = 3'd4,
        OpRotate = 3'd5,
        OpInv6   = 3'd6,
        OpInv7   = 3'd7
    } op_e;

    // Stage 1: operation capture
    logic                    valid_q;
    op_e                     opcode_q;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic                    cin_q;
    logic                    serial_q;
    logic                    dir_q;
    logic                    red_a_q;
    logic                    red_b_q;
    logic                    byp_a_q;
    logic                    byp_b_q;

    // Stage 2: result registers
    logic signed [OW-1:0]    out_q;
    logic                    out_valid_q;
    logic [LED_W-1:0]        leds_q;

    logic signed [OW-1:0]    a_ext;
    logic signed [OW-1:0]    b_ext;
    logic signed [OW-1:0]    result;
    logic                    invalid;
    logic                    bypass;
    logic                    use_byp_a;
    logic                    use_red_a;
    logic [WIDTH-1:0]        red_opnd;
    logic                    red_bit;
    logic                    cin_add;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= OpOr;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            serial_q <= 1'b0;
            dir_q    <= 1'b0;
            red_a_q  <= 1'b0;
            red_b_q  <= 1'b0;
            byp_a_q  <= 1'b0;
            byp_b_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                opcode_q <= op_e'(opcode);
                a_q      <= A;
                b_q      <= B;
                cin_q    <= cin;
                serial_q <= serial_in;
                dir_q    <= direction;
                red_a_q  <= red_op_A;
                red_b_q  <= red_op_B;
                byp_a_q  <= bypass_A;
                byp_b_q  <= bypass_B;
            end
        end
    end

    assign a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign bypass    = byp_a_q | byp_b_q;
    assign use_byp_a = byp_a_q & (~byp_b_q | PrioA);
    assign use_red_a = red_a_q & (~red_b_q | PrioA);
    assign red_opnd  = use_red_a ? a_q : b_q;
    assign red_bit   = (opcode_q == OpOr) ? |red_opnd : ^red_opnd;
    assign cin_add   = UseCin ? cin_q : 1'b0;

    // Reduction flags are only meaningful for the bitwise ops
    assign invalid = (opcode_q inside {OpInv6, OpInv7}) |
                     ((red_a_q | red_b_q) & ~(opcode_q inside {OpOr, OpXor}));

    always_comb begin
        result = '0;
        if (bypass) begin
            result = use_byp_a ? a_ext : b_ext;
        end else if (!invalid) begin
            unique case (opcode_q)
                OpOr: begin
                    if (red_a_q || red_b_q) result = {{(OW-1){1'b0}}, red_bit};
                    else                    result = a_ext | b_ext;
                end
                OpXor: begin
                    if (red_a_q || red_b_q) result = {{(OW-1){1'b0}}, red_bit};
                    else                    result = a_ext ^ b_ext;
                end
                OpAdd:    result = a_ext + b_ext + {{(OW-1){1'b0}}, cin_add};
                OpMult:   result = a_ext * b_ext;
                OpShift:  result = dir_q ? {out_q[OW-2:0], serial_q} : {serial_q, out_q[OW-1:1]};
                OpRotate: result = dir_q ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
                default:  result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            leds_q      <= '0;
        end else begin
            out_valid_q <= valid_q;
            if (valid_q) begin
                out_q  <= result;
                leds_q <= (invalid && !bypass) ? ~leds_q : '0;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign leds      = leds_q;

`ifdef ALSU_PARAM_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (valid_q && invalid && !bypass && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
